// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt state: Status, Cause, Count/Compare, hw_int synchronisers and masked interrupt flags.
// Define TIMER_INT_EN to build Count/Compare and the timer interrupt; otherwise the timer logic is absent.
module cp0_int_ctrl #(
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        cp0_wr_exp,
    input  logic        cp0_clean_exl,
    output logic [7:0]  interrupt_flags,
    output logic        allow_int,
    output logic        timer_int
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  sync_hw;
    logic [7:0]  ip;
    logic        wr_status, wr_cause, wr_count, wr_compare;
    logic        timer_pending;
    logic [31:0] count_rd, compare_rd;
    logic        unused_wdata;

    assign unused_wdata = ^cp0_wdata;

    assign wr_status  = cp0_we && (cp0_waddr == 5'd12);
    assign wr_cause   = cp0_we && (cp0_waddr == 5'd13);
    assign wr_count   = cp0_we && (cp0_waddr == 5'd9);
    assign wr_compare = cp0_we && (cp0_waddr == 5'd11);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], hw_int};
    end

    assign sync_hw = sync_q[SYNC_STAGES-1];

    // Exception entry outranks ERET, which outranks an MTC0 to Status for EXL only.
    always_comb begin
        im_d    = im_q;
        ie_d    = ie_q;
        exl_d   = exl_q;
        ip_sw_d = ip_sw_q;
        if (wr_status) begin
            im_d  = cp0_wdata[15:8];
            ie_d  = cp0_wdata[0];
            exl_d = cp0_wdata[1];
        end
        if (cp0_wr_exp) begin
            exl_d = 1'b1;
        end else if (cp0_clean_exl) begin
            exl_d = 1'b0;
        end
        if (wr_cause) begin
            ip_sw_d = cp0_wdata[9:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            im_q    <= '0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            ip_sw_q <= '0;
        end else begin
            sync_q  <= sync_d;
            im_q    <= im_d;
            exl_q   <= exl_d;
            ie_q    <= ie_d;
            ip_sw_q <= ip_sw_d;
        end
    end

`ifdef TIMER_INT_EN
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timer_pending_q, timer_pending_d;

    // Register writes override both the prescaler increment and a same-cycle match.
    always_comb begin
        presc_d         = presc_q + PW'(1);
        count_d         = count_q;
        compare_d       = compare_q;
        timer_pending_d = timer_pending_q;
        if (presc_q == PW'(COUNT_DIV - 1)) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end
        if (count_q == compare_q) begin
            timer_pending_d = 1'b1;
        end
        if (wr_count) begin
            count_d = cp0_wdata;
            presc_d = '0;
        end
        if (wr_compare) begin
            compare_d       = cp0_wdata;
            timer_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q         <= '0;
            compare_q       <= '0;
            presc_q         <= '0;
            timer_pending_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            compare_q       <= compare_d;
            presc_q         <= presc_d;
            timer_pending_q <= timer_pending_d;
        end
    end

    assign timer_pending = timer_pending_q;
    assign count_rd      = count_q;
    assign compare_rd    = compare_q;
`else
    assign timer_pending = 1'b0;
    assign count_rd      = '0;
    assign compare_rd    = '0;
`endif

    assign ip              = {sync_hw[5] | timer_pending, sync_hw[4:0], ip_sw_q};
    assign interrupt_flags = ip & im_q;
    assign allow_int       = ie_q & ~exl_q;
    assign timer_int       = timer_pending;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            5'd9:    cp0_rdata = count_rd;
            5'd11:   cp0_rdata = compare_rd;
            5'd12:   cp0_rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
            5'd13:   cp0_rdata = {16'b0, ip, 8'b0};
            default: cp0_rdata = '0;
        endcase
    end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Holds the CP0 interrupt-related state: Status (IM/EXL/IE), Cause (IP), Count and Compare.
- Synchronises external hardware interrupt lines, generates the timer interrupt, and produces the masked interrupt_flags[7:0] and allow_int signals consumed by the exception unit.
- Updates EXL from the exception unit's cp0_wr_exp / cp0_clean_exl pulses.
- Sits beside the exception unit in the MEM stage; it is written by MTC0 and read by MFC0.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles; legal range 1..16.
- SYNC_STAGES, 2, flop stages on each hw_int line; legal range 2..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- hw_int  in  6  asynchronous external interrupt lines, level-sensitive
- cp0_we  in  1  MTC0 write strobe
- cp0_waddr  in  5  CP0 write register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 read register number
- cp0_rdata  out  32  MFC0 data, combinational from registers
- cp0_wr_exp  in  1  exception taken this cycle (from exception unit)
- cp0_clean_exl  in  1  ERET committed this cycle
- interrupt_flags  out  8  Cause.IP & Status.IM
- allow_int  out  1  Status.IE & ~Status.EXL
- timer_int  out  1  timer interrupt pending

Behaviour:
- Reset values: all registers 0 (Status, IP[1:0], Count, Compare, prescaler, sync flops, timer_pending). Consequently interrupt_flags=0, allow_int=0, timer_int=0, cp0_rdata=0 for every address.
- Register map:
  - 9 = Count.
  - 11 = Compare.
  - 12 = Status: only bits [15:8] IM, [1] EXL and [0] IE are implemented; all other bits read 0.
  - 13 = Cause: only IP bits [15:8] are implemented; all other bits read 0.
  - All other addresses read 0; writes to them are ignored.
- Hardware sync: each hw_int bit passes through SYNC_STAGES flops. IP[7:2] = sync_hw[5:0], with IP7 additionally ORed with timer_pending. Latency from hw_int edge to interrupt_flags is SYNC_STAGES cycles, plus 0 cycles combinational.
- Software interrupts: IP[1:0] are written by MTC0 to Cause bits [9:8]. Cause bits [15:10] are read-only; writes to them are ignored.
- Prescaler: counts 0..COUNT_DIV-1. Count increments by 1 when the prescaler equals COUNT_DIV-1. Count wraps 0xFFFFFFFF -> 0 with no flag.
- Timer set: timer_pending is set in the cycle after Count (post-increment value) equals Compare. It stays set until Compare is written.
- Compare write: loads Compare, clears timer_pending, takes effect next cycle.
  - If a match and a Compare write occur in the same cycle, the write wins and timer_pending = 0.
- Count write: loads Count and clears the prescaler; the write wins over an increment in the same cycle.
- Status write: loads IM, EXL, IE from wdata[15:8], [1], [0].
- EXL priority, highest first: cp0_wr_exp sets EXL=1; else cp0_clean_exl clears EXL=0; else an MTC0 write to Status. When cp0_wr_exp coincides with a Status write, IM and IE take wdata and EXL=1.
- Outputs:
  - allow_int and interrupt_flags are combinational from the current registers.
  - The exception unit sees a new EXL value in the cycle after the update.
- Read/write in the same cycle to the same address: cp0_rdata returns the old value; there is no bypass.

Optional Feature:
- Macro TIMER_INT_EN.
- Defined: Count/Compare/prescaler/timer_pending are implemented as above.
- Undefined:
  - No Count, Compare or prescaler flops.
  - Reads of 9 and 11 return 0; writes are ignored.
  - timer_int is tied 0, and IP7 = sync_hw[5] only.

Test Plan:
- Reset: assert rst mid-run with Count=0x55 and EXL=1 -> all outputs 0 immediately, without waiting for a clock edge; cp0_rdata(12)=0.
- Hardware interrupt:
  - Setup: Status write 0x0000_0401 (IM2, IE).
  - Stimulus: raise hw_int[0].
  - Required: interrupt_flags=0x04 and allow_int=1 exactly SYNC_STAGES=2 cycles later; drop hw_int[0] -> flags return to 0 after 2 cycles.
- Timer (TIMER_INT_EN, COUNT_DIV=2):
  - Stimulus: write Count=0, Compare=3.
  - Required: timer_int rises after 6 cycles + 1; IP7 is set; writing Compare=0x10 clears it the next cycle.
- EXL priority: assert cp0_wr_exp and MTC0 Status=0x0000_FF01 in the same cycle -> Status reads 0x0000_FF03 and allow_int=0; then cp0_clean_exl -> Status=0x0000_FF01 and allow_int=1.
- Software interrupt: write Cause=0x0000_0300 with IM=0x03 and IE=1 -> interrupt_flags=0x03 next cycle; Cause bits [15:10] remain unaffected by the written value.
- Count wrap: write Count=0xFFFF_FFFF -> reads 0 after COUNT_DIV cycles; a Count write coinciding with an increment -> the written value holds and the prescaler restarts.
